wb_stage_seq: RTL and testbench

Registered, parametrised writeback stage for the RISC-V core. It sits between execute/memory and the register file. It accepts one retiring instruction at a time and selects the result: ALU output, U-type immediate, PC link, or a load.
- Loads: waits on a memory-ack handshake, with a timeout.
- Load formatting: byte/halfword/word lane selection driven by the address low bits.
- Result delivery: a single-cycle register-file write strobe.
- Width: generalised to XLEN 32 or 64, adding LWU/LD for 64.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/load_align.sv | 63 ++++++
 rtl/wb_stage_seq.sv | 169 ++++++++++++++++
 tb/tb_wb_stage_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the core pipeline: decoded ops, writeback FSM states and helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LB,
    OP_LH,
    OP_LW,
    OP_LBU,
    OP_LHU,
    OP_LWU,
    OP_LD,
    OP_AUIPC,
    OP_LUI,
    OP_JAL,
    OP_JALR,
    OP_OTHER
  } cu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } wb_state_t;

  localparam int LINK_OFFSET = 4;

  function automatic logic is_load(cu_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/half/word lane from an aligned
// memory word and extends it; flags misaligned or width-illegal accesses.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  cu_op_t            op,
  input  logic [2:0]        addr_lo,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   data,
  output logic              misalign
);

  localparam bit WIDE = (XLEN == 64);

  logic [2:0]  b_lane;
  logic [1:0]  h_lane;
  logic        w_lane;
  logic [63:0] rd64;
  logic [7:0]  b8;
  logic [15:0] h16;
  logic [31:0] w32;

  always_comb begin
    // In a 32-bit core addr_lo[2] lies outside the memory word, so lanes ignore it.
    b_lane   = WIDE ? addr_lo : {1'b0, addr_lo[1:0]};
    h_lane   = WIDE ? addr_lo[2:1] : {1'b0, addr_lo[1]};
    w_lane   = WIDE ? addr_lo[2] : 1'b0;
    rd64     = 64'(rdata);
    b8       = rd64[{b_lane, 3'b000} +: 8];
    h16      = rd64[{h_lane, 4'b0000} +: 16];
    w32      = rd64[{w_lane, 5'b00000} +: 32];
    data     = '0;
    misalign = 1'b0;
    case (op)
      OP_LB:  data = XLEN'($signed(b8));
      OP_LBU: data = XLEN'(b8);
      OP_LH: begin
        data     = XLEN'($signed(h16));
        misalign = addr_lo[0];
      end
      OP_LHU: begin
        data     = XLEN'(h16);
        misalign = addr_lo[0];
      end
      OP_LW: begin
        data     = XLEN'($signed(w32));
        misalign = (addr_lo[1:0] != 2'b00);
      end
      OP_LWU: begin
        data     = XLEN'(w32);
        misalign = !WIDE || (addr_lo[1:0] != 2'b00);
      end
      OP_LD: begin
        data     = rdata;
        misalign = !WIDE || (addr_lo != 3'b000);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage_seq.sv
// Writeback stage: selects the retiring result, waits on memory for loads
// (with timeout) and issues a one-cycle register-file write.
module wb_stage_seq
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  cu_op_t            in_op,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_alu_out,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall,
  output logic              busy,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              load_err,
  output wb_state_t         dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshake: in_* is taken only in IDLE when in_valid=1; while stall=1 upstream
  // holds in_*. mem_ack is a single-cycle qualifier sampled only in WAIT_MEM.
  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cu_op_t           op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       addr_lo_q, addr_lo_d;
  logic             from_load_q, from_load_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             load_err_q, load_err_d;
  logic             stall_c;

  cu_op_t           align_op;
  logic [2:0]       align_addr;
  logic [XLEN-1:0]  align_data;
  logic             align_bad;
  logic [XLEN-1:0]  imm_u;
  logic [XLEN-1:0]  result;
  logic             unused_imm_lo;

  assign unused_imm_lo = ^in_imm[11:0];

  load_align #(.XLEN(XLEN)) u_align (
    .op       (align_op),
    .addr_lo  (align_addr),
    .rdata    (mem_rdata),
    .data     (align_data),
    .misalign (align_bad)
  );

  always_comb begin
    imm_u = {in_imm[XLEN-1:12], 12'b0};
    case (in_op)
      OP_LUI:         result = imm_u;
      OP_AUIPC:       result = in_pc + imm_u;
      OP_JAL, OP_JALR: result = in_pc + XLEN'(LINK_OFFSET);
      default:        result = in_alu_out;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    addr_lo_d   = addr_lo_q;
    from_load_d = from_load_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    load_err_d  = 1'b0;
    stall_c     = 1'b0;
    // The misalign check looks at the incoming op in IDLE, the latched one afterwards.
    align_op    = (state_q == IDLE) ? in_op : op_q;
    align_addr  = (state_q == IDLE) ? in_alu_out[2:0] : addr_lo_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_load(in_op)) begin
            if (align_bad) begin
              load_err_d = 1'b1;
            end else begin
              state_d     = WAIT_MEM;
              cnt_d       = CNT_W'(1);
              op_d        = in_op;
              rd_d        = in_rd;
              addr_lo_d   = in_alu_out[2:0];
              from_load_d = 1'b1;
              stall_c     = 1'b1;
            end
          end else begin
            state_d     = WRITE;
            from_load_d = 1'b0;
            rf_we_d     = (in_rd != 5'd0);
            rf_waddr_d  = in_rd;
            rf_wdata_d  = result;
          end
        end
      end
      WAIT_MEM: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          state_d    = WRITE;
          cnt_d      = '0;
          rf_we_d    = (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          rf_wdata_d = align_data;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        stall_c = from_load_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_OTHER;
      rd_q        <= '0;
      addr_lo_q   <= '0;
      from_load_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      addr_lo_q   <= addr_lo_d;
      from_load_q <= from_load_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      load_err_q  <= load_err_d;
    end
  end

  assign stall     = stall_c;
  assign busy      = (state_q != IDLE);
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign load_err  = load_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_stage_seq.sv
// Directed bench for wb_stage_seq: a 32-bit and a 64-bit instance share clock and reset.
module tb_wb_stage_seq;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid, a_mem_ack, a_stall, a_busy, a_rf_we, a_load_err;
  cu_op_t      a_in_op;
  logic [4:0]  a_in_rd, a_rf_waddr;
  logic [31:0] a_in_alu_out, a_in_pc, a_in_imm, a_mem_rdata, a_rf_wdata;
  wb_state_t   a_dbg;

  logic        b_in_valid, b_mem_ack, b_stall, b_busy, b_rf_we, b_load_err;
  cu_op_t      b_in_op;
  logic [4:0]  b_in_rd, b_rf_waddr;
  logic [63:0] b_in_alu_out, b_in_pc, b_in_imm, b_mem_rdata, b_rf_wdata;
  wb_state_t   b_dbg;

  wb_stage_seq #(.XLEN(32), .TIMEOUT(16)) dut32 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_op(a_in_op), .in_rd(a_in_rd),
    .in_alu_out(a_in_alu_out), .in_pc(a_in_pc), .in_imm(a_in_imm),
    .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata), .stall(a_stall), .busy(a_busy),
    .rf_we(a_rf_we), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
    .load_err(a_load_err), .dbg_state(a_dbg)
  );

  wb_stage_seq #(.XLEN(64), .TIMEOUT(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_op(b_in_op), .in_rd(b_in_rd),
    .in_alu_out(b_in_alu_out), .in_pc(b_in_pc), .in_imm(b_in_imm),
    .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .stall(b_stall), .busy(b_busy),
    .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
    .load_err(b_load_err), .dbg_state(b_dbg)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic wide, input logic v, input cu_op_t op, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] imm,
                       input logic ack, input logic [63:0] rdata);
    if (wide) begin
      b_in_valid = v; b_in_op = op; b_in_rd = rd; b_in_alu_out = alu;
      b_in_pc = pc; b_in_imm = imm; b_mem_ack = ack; b_mem_rdata = rdata;
    end else begin
      a_in_valid = v; a_in_op = op; a_in_rd = rd; a_in_alu_out = alu[31:0];
      a_in_pc = pc[31:0]; a_in_imm = imm[31:0]; a_mem_ack = ack; a_mem_rdata = rdata[31:0];
    end
  endtask

  function automatic logic s_stall(input logic wide);
    return wide ? b_stall : a_stall;
  endfunction
  function automatic logic s_busy(input logic wide);
    return wide ? b_busy : a_busy;
  endfunction
  function automatic logic s_we(input logic wide);
    return wide ? b_rf_we : a_rf_we;
  endfunction
  function automatic logic s_err(input logic wide);
    return wide ? b_load_err : a_load_err;
  endfunction
  function automatic logic [63:0] s_wdata(input logic wide);
    return wide ? b_rf_wdata : {32'b0, a_rf_wdata};
  endfunction
  function automatic logic [4:0] s_waddr(input logic wide);
    return wide ? b_rf_waddr : a_rf_waddr;
  endfunction

  // Cycle 0 presents the instruction; later cycles are numbered from acceptance.
  task automatic run_alu(input string tag, input logic wide, input cu_op_t op, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] exp_data);
    int we_cyc = -1;
    int stall_n = 0;
    logic [63:0] data = '0;
    logic [4:0]  waddr = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(wide, c == 0, op, rd, alu, pc, imm, 1'b0, 64'd0);
      #1;
      if (s_stall(wide)) stall_n++;
      if (s_we(wide) && we_cyc < 0) begin
        we_cyc = c;
        data   = s_wdata(wide);
        waddr  = s_waddr(wide);
      end
    end
    chk({tag, "_we_cyc"}, 64'(we_cyc), 64'(1));
    chk({tag, "_wdata"}, data, exp_data);
    chk({tag, "_waddr"}, 64'(waddr), 64'(rd));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(0));
  endtask

  task automatic run_load(input string tag, input logic wide, input cu_op_t op, input logic [4:0] rd,
                          input logic [63:0] addr, input logic [63:0] rdata, input int ack_cyc,
                          input int n_cyc, input int exp_we, input logic [63:0] exp_data,
                          input int exp_err, input int exp_stall, input int exp_busy);
    int we_cyc = -1;
    int err_cyc = -1;
    int stall_n = 0;
    int last_busy = -1;
    logic [63:0] data = '0;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      drive(wide, c == 0, op, rd, addr, 64'd0, 64'd0, (c > 0) && (c == ack_cyc), rdata);
      #1;
      if (s_stall(wide)) stall_n++;
      if (s_busy(wide)) last_busy = c;
      if (s_we(wide) && we_cyc < 0) begin
        we_cyc = c;
        data   = s_wdata(wide);
      end
      if (s_err(wide) && err_cyc < 0) err_cyc = c;
    end
    chk({tag, "_we_cyc"}, 64'(we_cyc), 64'(exp_we));
    chk({tag, "_wdata"}, data, exp_data);
    chk({tag, "_err_cyc"}, 64'(err_cyc), 64'(exp_err));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
    chk({tag, "_last_busy"}, 64'(last_busy), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, OP_OTHER, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    drive(1'b1, 1'b0, OP_OTHER, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    #1;
    chk("reset_state", 64'(a_dbg), 64'(IDLE));
    chk("reset_outs32", {a_stall, a_busy, a_rf_we, a_load_err, a_rf_waddr, a_rf_wdata}, 64'd0);
    chk("reset_outs64", {b_stall, b_busy, b_rf_we, b_load_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-load results, including wrap-around of the link address.
    run_alu("alu",   1'b0, OP_OTHER, 5'd5, 64'h1234, 64'd0, 64'd0, 64'h0000_1234);
    run_alu("auipc", 1'b0, OP_AUIPC, 5'd6, 64'd0, 64'h1000, 64'h0001_2000, 64'h0001_3000);
    run_alu("jal",   1'b0, OP_JAL,   5'd1, 64'd0, 64'hFFFF_FFFC, 64'd0, 64'h0000_0000);
    run_alu("jalr",  1'b0, OP_JALR,  5'd2, 64'd0, 64'h100, 64'd0, 64'h104);
    run_alu("lui",   1'b0, OP_LUI,   5'd7, 64'd0, 64'd0, 64'hABCD_E123, 64'hABCD_E000);
    run_alu("auipc64", 1'b1, OP_AUIPC, 5'd8, 64'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 64'd0);

    // Loads on the 32-bit instance.
    run_load("lb",   1'b0, OP_LB,  5'd3, 64'h103, 64'h80FF_FFFF, 2, 5, 3, 64'hFFFF_FF80, -1, 4, 3);
    run_load("lbu",  1'b0, OP_LBU, 5'd3, 64'h103, 64'h80FF_FFFF, 2, 5, 3, 64'h0000_0080, -1, 4, 3);
    run_load("lh",   1'b0, OP_LH,  5'd4, 64'h102, 64'h8001_0000, 1, 4, 2, 64'hFFFF_8001, -1, 3, 2);
    run_load("lhu",  1'b0, OP_LHU, 5'd4, 64'h102, 64'h8001_0000, 1, 4, 2, 64'h0000_8001, -1, 3, 2);
    run_load("lh_mis", 1'b0, OP_LH, 5'd4, 64'h101, 64'd0, 99, 3, -1, 64'd0, 1, 0, -1);
    run_load("lwu32", 1'b0, OP_LWU, 5'd4, 64'h200, 64'd0, 99, 3, -1, 64'd0, 1, 0, -1);
    run_load("lw_tmo", 1'b0, OP_LW, 5'd9, 64'h200, 64'd0, 99, 19, -1, 64'd0, 16, 16, 15);
    run_load("lw_ack15", 1'b0, OP_LW, 5'd9, 64'h200, 64'h1234_5678, 15, 18, 16, 64'h1234_5678, -1, 17, 16);
    run_load("lw_x0", 1'b0, OP_LW, 5'd0, 64'h204, 64'h5555_AAAA, 2, 5, -1, 64'd0, -1, 4, 3);

    // Reset in the middle of WAIT_MEM drops the load; a stray ack writes nothing.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_LW, 5'd10, 64'h300, 64'd0, 64'd0, 1'b0, 64'hCAFE_F00D);
    @(negedge clk);
    drive(1'b0, 1'b0, OP_LW, 5'd10, 64'h300, 64'd0, 64'd0, 1'b0, 64'hCAFE_F00D);
    @(negedge clk);
    #1;
    chk("rst_pre_state", 64'(a_dbg), 64'(WAIT_MEM));
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {a_stall, a_busy, a_rf_we, a_load_err, a_rf_waddr, a_rf_wdata}, 64'd0);
    chk("rst_mid_state", 64'(a_dbg), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    a_mem_ack = 1'b1;
    @(negedge clk);
    a_mem_ack = 1'b0;
    #1;
    chk("rst_ack_we", {a_rf_we, a_busy}, 64'd0);
    @(negedge clk);
    #1;
    chk("rst_ack_we2", {a_rf_we, a_busy, a_load_err}, 64'd0);

    // 64-bit lanes and the LWU/LD extensions.
    run_load("lwu64", 1'b1, OP_LWU, 5'd11, 64'h1004, 64'hDEAD_BEEF_0000_0001, 2, 5, 3,
             64'h0000_0000_DEAD_BEEF, -1, 4, 3);
    run_load("ld_mis", 1'b1, OP_LD, 5'd11, 64'h1004, 64'd0, 99, 3, -1, 64'd0, 1, 0, -1);
    run_load("ld64", 1'b1, OP_LD, 5'd12, 64'h1000, 64'h0123_4567_89AB_CDEF, 1, 4, 2,
             64'h0123_4567_89AB_CDEF, -1, 3, 2);
    run_load("lw64", 1'b1, OP_LW, 5'd13, 64'h1004, 64'h8000_0000_0000_0001, 1, 4, 2,
             64'hFFFF_FFFF_8000_0000, -1, 3, 2);
    run_load("lb64", 1'b1, OP_LB, 5'd14, 64'h1007, 64'h7F00_0000_0000_0000, 1, 4, 2,
             64'h0000_0000_0000_007F, -1, 3, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
